// File: rtl/addsub_acc_pkg.sv
// rtl/addsub_acc_pkg.sv - shared op encodings for the add/sub accumulator
package addsub_acc_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  function automatic logic op_uses_adder(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/addsub_acc_cla.sv
// rtl/addsub_acc_cla.sv - combinational carry-lookahead add/sub unit (S = A + (B ^ M) + M)
module addsub_cla #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_m,
  output logic [W-1:0] o_s,
  output logic         o_c,
  output logic         o_v
);

  logic [W-1:0] w_bx;
  logic [W-1:0] w_p;
  logic [W-1:0] w_g;
  logic [W:0]   w_c;

  assign w_bx = i_b ^ {W{i_m}};
  assign w_p  = i_a ^ w_bx;
  assign w_g  = i_a & w_bx;

  // Each carry is the flattened lookahead sum-of-products over all lower bits.
  always_comb begin : carry_lookahead
    logic l_term;
    logic l_prop;
    l_term = 1'b0;
    l_prop = 1'b1;
    w_c    = '0;
    w_c[0] = i_m;
    for (int i = 0; i < W; i++) begin
      l_term = 1'b0;
      l_prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        l_term = l_term | (l_prop & w_g[j]);
        l_prop = l_prop & w_p[j];
      end
      w_c[i+1] = l_term | (l_prop & i_m);
    end
  end

  assign o_s = w_p ^ w_c[W-1:0];
  assign o_c = w_c[W];
  assign o_v = w_c[W] ^ w_c[W-1];

endmodule

// File: rtl/addsub_acc.sv
// rtl/addsub_acc.sv - handshaked accumulator stage with registered result and C/V/N/Z flags
module addsub_acc
  import addsub_acc_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    result,
  output logic            c_out,
  output logic            v_out,
  output logic            n_out,
  output logic            z_out,
  output logic            ovf_sticky
);

  logic [W-1:0] r_acc;
  logic         r_out_valid;
  logic         r_c;
  logic         r_v;
  logic         r_n;
  logic         r_z;
  logic         r_sticky;

  op_e          w_op;
  logic         w_accept;
  logic [W-1:0] w_sum;
  logic         w_cla_c;
  logic         w_cla_v;
  logic [W-1:0] w_acc_nxt;
  logic         w_c_nxt;
  logic         w_v_nxt;
  logic         w_sticky_nxt;

  assign w_op     = op_e'(op);
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  addsub_cla #(.W(W)) u_cla (
    .i_a (r_acc),
    .i_b (b),
    .i_m (w_op == OP_SUB),
    .o_s (w_sum),
    .o_c (w_cla_c),
    .o_v (w_cla_v)
  );

  always_comb begin
    w_acc_nxt    = r_acc;
    w_c_nxt      = 1'b0;
    w_v_nxt      = 1'b0;
    w_sticky_nxt = r_sticky;
    if (op_uses_adder(w_op)) begin
      w_acc_nxt    = w_sum;
      w_c_nxt      = w_cla_c;
      w_v_nxt      = w_cla_v;
      w_sticky_nxt = r_sticky | w_cla_v;
    end else if (w_op == OP_LOAD) begin
      w_acc_nxt = b;
    end else begin
      w_acc_nxt    = '0;
      w_sticky_nxt = 1'b0;
    end
  end

  // The accumulator doubles as the result register, so a drained result is still the next operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_n         <= 1'b0;
      r_z         <= 1'b1;
      r_sticky    <= 1'b0;
    end else if (w_accept) begin
      r_acc       <= w_acc_nxt;
      r_out_valid <= 1'b1;
      r_c         <= w_c_nxt;
      r_v         <= w_v_nxt;
      r_n         <= w_acc_nxt[W-1];
      r_z         <= (w_acc_nxt == '0);
      r_sticky    <= w_sticky_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign result     = r_acc;
  assign out_valid  = r_out_valid;
  assign c_out      = r_c;
  assign v_out      = r_v;
  assign n_out      = r_n;
  assign z_out      = r_z;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_addsub_acc.sv
// tb/tb_addsub_acc.sv - directed self-checking bench for addsub_acc (W=4)
module tb_addsub_acc;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         c_out;
  logic         v_out;
  logic         n_out;
  logic         z_out;
  logic         ovf_sticky;

  int n_checks;
  int n_errors;

  addsub_acc #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .c_out      (c_out),
    .v_out      (v_out),
    .n_out      (n_out),
    .z_out      (z_out),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] r, input logic vld,
                         input logic c, input logic v, input logic n, input logic z,
                         input logic s);
    chk({tag, ".result"}, 32'(result), 32'(r));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
    chk({tag, ".c"}, 32'(c_out), 32'(c));
    chk({tag, ".v"}, 32'(v_out), 32'(v));
    chk({tag, ".n"}, 32'(n_out), 32'(n));
    chk({tag, ".z"}, 32'(z_out), 32'(z));
    chk({tag, ".sticky"}, 32'(ovf_sticky), 32'(s));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] o, input logic [W-1:0] v);
    in_valid = 1'b1;
    op       = o;
    b        = v;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'd0;
    b         = '0;
    out_ready = 1'b1;
    step();
    step();
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    cmd(2'd0, 4'd5);
    chk_all("load5", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd(2'd1, 4'd3);
    chk_all("add3", 4'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    chk("drain.result_hold", 32'(result), 32'd8);

    cmd(2'd0, 4'd3);
    cmd(2'd2, 4'd5);
    chk_all("sub5", 4'd14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cmd(2'd2, 4'd14);
    chk_all("sub14", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    cmd(2'd0, 4'd1);
    cmd(2'd1, 4'd15);
    chk_all("add15", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cmd(2'd3, 4'd9);
    chk_all("clr", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    out_ready = 1'b0;
    cmd(2'd0, 4'd4);
    chk_all("bp.load4", 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    op       = 2'd1;
    b        = 4'd2;
    for (int i = 0; i < 3; i++) begin
      chk("bp.in_ready_low", 32'(in_ready), 32'd0);
      step();
      chk("bp.result_hold", 32'(result), 32'd4);
      chk("bp.valid_hold", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_high", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk_all("bp.add2", 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    cmd(2'd0, 4'd0);
    in_valid = 1'b1;
    op       = 2'd1;
    b        = 4'd1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("stream%0d.result", i), 32'(result), 32'(i % 16));
      chk($sformatf("stream%0d.c", i), 32'(c_out), 32'(i == 16));
      chk($sformatf("stream%0d.v", i), 32'(v_out), 32'(i == 8));
      chk($sformatf("stream%0d.valid", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    chk("stream.sticky", 32'(ovf_sticky), 32'd1);

    cmd(2'd0, 4'd9);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midreset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("midreset.in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    cmd(2'd1, 4'd3);
    chk_all("post_reset.add3", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addsub_acc.md
# addsub_acc

Registered accumulator stage wrapped around the combinational carry-lookahead add/sub unit. It accepts one command per handshake (load, clear, add, subtract), applies it to an internal W-bit accumulator, and presents the result with C/V/N/Z flags in a one-entry output register. It is the sequential stage that turns the combinational adder into a usable datapath element for the downstream controller.

## Interface
- W, 4: datapath width in bits (W >= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  command present
- in_ready  output  1  stage can accept a command this cycle
- op  input  2  command: 0 LOAD, 1 ADD, 2 SUB, 3 CLR
- b  input  W  operand; ignored for CLR
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer takes the result this cycle
- result  output  W  accumulator value after the command
- c_out  output  1  adder carry-out; for SUB, 1 = no borrow
- v_out  output  1  signed overflow, c[W] xor c[W-1]
- n_out  output  1  result[W-1]
- z_out  output  1  result == 0
- ovf_sticky  output  1  set by any accepted ADD/SUB with overflow; cleared only by CLR or reset

## Operation
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready (combinational; the result register is overwritten in the same cycle it drains).
- On accept:
  - LOAD: acc <= b; C=V=0.
  - CLR: acc <= 0; C=V=0; ovf_sticky <= 0.
  - ADD: acc <= acc + b via adder with M=0; C, V from adder.
  - SUB: acc <= acc - b via adder with M=1 (A + ~B + 1); C, V from adder.
  - N, Z always from the new accumulator value.
  - result/flags registered; out_valid <= 1.
- No accept and out_ready: out_valid <= 0; result and flags hold their last values.
- No accept and !out_ready: everything holds.
- The accumulator is the result register: the next command operates on the last accepted result, whether or not it has been consumed.
- Arithmetic is modulo 2^W; no saturation. ovf_sticky is set on the accept that produces V=1. CLR in the same accept wins (sticky = 0).
- in_valid without in_ready: the command is not consumed and has no side effects. op/b may change freely while in_valid=0.

## Timing
- Reset (async assert, sync-released by the system): acc=0, result=0, out_valid=0, c_out=v_out=n_out=0, z_out=1, ovf_sticky=0; in_ready=1.
- Latency: command accepted at edge k produces out_valid=1 and a valid result after edge k, i.e. in cycle k+1.
- Throughput: one command per cycle while out_ready=1.
- Back-to-back: ADD accepted at k, ADD accepted at k+1 uses the acc written at k.
- Reset mid-operation: any pending result is discarded; no partial update survives.
- All outputs are registered except in_ready.

## Structure
- Shared package: op encodings (OP_LOAD=0, OP_ADD=1, OP_SUB=2, OP_CLR=3) and the op width.
- One sub-module: the existing addsub_cla, instantiated with W, A=acc, B=b, M=(op==OP_SUB). Its outputs are used only on ADD/SUB.
- Remaining logic: accept decode, next-state mux, output/flag register and sticky bit.

## Test plan
- Reset: hold rst_n=0 mid-stream -> result=0, out_valid=0, z_out=1, ovf_sticky=0, in_ready=1 while reset is asserted.
- W=4, out_ready=1: LOAD 5, then ADD 3 -> result=8, c_out=0, v_out=1, n_out=1, z_out=0, ovf_sticky=1 one cycle after the ADD accept.
- LOAD 3, then SUB 5 -> result=14, c_out=0 (borrow), v_out=0, n_out=1. Then SUB 14 -> result=0, c_out=1, z_out=1.
- LOAD 1, then ADD 15 -> result=0, c_out=1, v_out=0, z_out=1. ovf_sticky stays at its prior value; CLR then clears it to 0.
- Backpressure: out_ready=0 with out_valid=1 and in_valid=1 ADD 2 -> in_ready=0, acc/result unchanged for 3 cycles. Raise out_ready -> ADD accepted in that same cycle, and the new result appears next cycle.
- Streaming: out_ready=1, ADD 1 issued on 16 consecutive cycles from LOAD 0 -> result goes 1..15, then 0 with c_out=1. v_out=1 only on the step 7->8.
